// File: rtl/frame_capture_mc.sv
// Purpose: capture one frame of NUM_CH lock-step ADC samples (optionally decimated) into RAM,
//          then replay it as one wide AXI4-Stream with tlast on the final sample.
// Latency: tvalid rises 2 cycles after the last capture write (1-cycle RAM read + output register).
// Backpressure: full-rate streaming under tready; a prefetch stage plus the output register hold
//               data stable while stalled. Input samples are never back-pressured: samples that
//               arrive during STREAM are dropped and flagged on overrun.
// Ports: clk/rst (sync, active-high); s_din/s_din_valid capture input; arm/continuous/decim control;
//        m_axis_* stream output; busy, frame_done, overrun and state_o status.
module frame_capture_mc #(
  parameter int NUM_CH      = 2,
  parameter int DATA_WIDTH  = 14,
  parameter int FRAME_LEN   = 65536,
  parameter int ADDR_WIDTH  = 16,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_din,
  input  logic                         s_din_valid,
  input  logic                         arm,
  input  logic                         continuous,
  input  logic [DECIM_WIDTH-1:0]       decim,
  output logic [NUM_CH*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun,
  output logic [1:0]                   state_o
);

  localparam int DW = NUM_CH * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_STREAM  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [DECIM_WIDTH-1:0] ratio_q, ratio_d;
  logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d;
  logic                   rd_done_q, rd_done_d;   // every address of the frame has been read
  logic                   s1_vld_q, s1_vld_d;     // RAM output register holds a sample
  logic                   s1_last_q, s1_last_d;
  logic [DW-1:0]          s1_dat_q;
  logic                   out_vld_q, out_vld_d;
  logic                   out_last_q, out_last_d;
  logic [DW-1:0]          out_dat_q, out_dat_d;
  logic                   busy_q;

  logic                   wr_en, rd_en, out_rdy, hs, final_hs;
  logic [DECIM_WIDTH-1:0] eff_ratio;

  logic [DW-1:0] mem [FRAME_LEN];

  assign eff_ratio = (decim == '0) ? DECIM_WIDTH'(1) : decim;
  assign hs        = out_vld_q && m_axis_tready;
  assign final_hs  = hs && out_last_q;
  assign out_rdy   = !out_vld_q || m_axis_tready;

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    ratio_d    = ratio_q;
    dcnt_d     = dcnt_q;
    rd_done_d  = rd_done_q;
    s1_vld_d   = s1_vld_q;
    s1_last_d  = s1_last_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_dat_d  = out_dat_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          ratio_d   = eff_ratio;
          wr_addr_d = '0;
          dcnt_d    = '0;
          state_d   = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (s_din_valid) begin
          dcnt_d = (dcnt_q == ratio_q - DECIM_WIDTH'(1)) ? '0 : dcnt_q + DECIM_WIDTH'(1);
          if (dcnt_q == '0) begin
            wr_en     = 1'b1;
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            if (wr_addr_q == LAST_ADDR) begin
              state_d   = ST_STREAM;
              rd_addr_d = '0;
              rd_done_d = 1'b0;
            end
          end
        end
      end

      ST_STREAM: begin
        // Issue a read only when the RAM output register is empty or about to drain,
        // so a stall never overwrites a fetched sample.
        rd_en = !rd_done_q && (!s1_vld_q || out_rdy);
        if (rd_en) begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          rd_done_d = (rd_addr_q == LAST_ADDR);
          s1_last_d = (rd_addr_q == LAST_ADDR);
          s1_vld_d  = 1'b1;
        end else if (out_rdy) begin
          s1_vld_d  = 1'b0;
        end

        if (out_rdy) begin
          out_vld_d  = s1_vld_q;
          out_last_d = s1_vld_q && s1_last_q;
          if (s1_vld_q) out_dat_d = s1_dat_q;
        end

        if (final_hs) begin
          if (continuous) begin
            state_d   = ST_CAPTURE;
            ratio_d   = eff_ratio;
            wr_addr_d = '0;
            dcnt_d    = '0;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      ratio_q    <= DECIM_WIDTH'(1);
      dcnt_q     <= '0;
      rd_done_q  <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_dat_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      ratio_q    <= ratio_d;
      dcnt_q     <= dcnt_d;
      rd_done_q  <= rd_done_d;
      s1_vld_q   <= s1_vld_d;
      s1_last_q  <= s1_last_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_dat_q  <= out_dat_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  // Frame buffer: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr_q] <= s_din;
    if (rd_en) s1_dat_q <= mem[rd_addr_q];
  end

  assign m_axis_tdata  = out_dat_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tlast  = out_last_q;
  assign busy          = busy_q;
  assign frame_done    = final_hs;
  assign overrun       = (state_q == ST_STREAM) && s_din_valid;
  assign state_o       = state_q;

endmodule

// File: tb/tb_frame_capture_mc.sv
module tb_frame_capture_mc;

  localparam int NCH = 2;
  localparam int DW  = 14;
  localparam int FL  = 8;
  localparam int AW  = 3;
  localparam int DCW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*DW-1:0] s_din = '0;
  logic              s_din_valid = 1'b0;
  logic              arm = 1'b0;
  logic              continuous = 1'b0;
  logic [DCW-1:0]    decim = '0;
  logic [NCH*DW-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              busy;
  logic              frame_done;
  logic              overrun;
  logic [1:0]        state_o;

  frame_capture_mc #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .FRAME_LEN(FL), .ADDR_WIDTH(AW), .DECIM_WIDTH(DCW)
  ) dut (
    .clk(clk), .rst(rst), .s_din(s_din), .s_din_valid(s_din_valid), .arm(arm),
    .continuous(continuous), .decim(decim), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [NCH*DW:0] sb[$];   // {tlast, tdata}
  int beat_cnt = 0;
  int done_cnt = 0;
  int ovr_cnt  = 0;

  logic              prev_stall = 1'b0;
  logic [NCH*DW-1:0] prev_dat;
  logic              prev_last;
  logic              st_pend = 1'b0;
  logic [1:0]        st_exp;
  logic [NCH*DW:0]   mon_e;
  logic              rdy_toggle = 1'b0;
  int                rdy_phase = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [NCH*DW-1:0] pk(input int v);
    pk = {14'(100 + v), 14'(v)};
  endfunction

  task automatic push_frame(input int start, input int step);
    for (int i = 0; i < FL; i++) sb.push_back({(i == FL - 1), pk(start + i * step)});
  endtask

  task automatic nck();
    @(negedge clk);
    #1;
  endtask

  task automatic arm_pulse(input int d);
    @(posedge clk); #1;
    arm = 1'b1;
    decim = DCW'(d);
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic drive_frame(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      s_din_valid = 1'b1;
      s_din = pk(base + k);
    end
    @(posedge clk); #1;
    s_din_valid = 1'b0;
  endtask

  task automatic wait_frame(input int target);
    bit ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (done_cnt >= target && state_o == 2'd0) ok = 1;
      else nck();
    end
    chk("frame_complete", 32'(ok), 1);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  task automatic wait_beats(input int target);
    bit ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (beat_cnt >= target) ok = 1;
      else nck();
    end
    chk("beat_reached", 32'(ok), 1);
  endtask

  // AXI-S ready: constant 1, or the repeating pattern 1,0,0.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_toggle) begin
        m_axis_tready = (rdy_phase == 0);
        rdy_phase = (rdy_phase + 1) % 3;
      end else begin
        m_axis_tready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      st_pend = 1'b0;
    end else begin
      if (st_pend) begin
        chk("state_after_last", state_o, st_exp);
        st_pend = 1'b0;
      end
      if (prev_stall) begin
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_tdata", m_axis_tdata, prev_dat);
        chk("stall_tlast", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: actual tdata %0h required no beat", m_axis_tdata);
        end else begin
          mon_e = sb.pop_front();
          chk("beat_tdata", m_axis_tdata, mon_e[NCH*DW-1:0]);
          chk("beat_tlast", m_axis_tlast, mon_e[NCH*DW]);
          chk("beat_frame_done", frame_done, mon_e[NCH*DW]);
          if (mon_e[NCH*DW]) begin
            st_exp = continuous ? 2'd1 : 2'd0;
            st_pend = 1'b1;
          end
        end
        beat_cnt++;
      end else begin
        chk("frame_done_no_hs", frame_done, 0);
      end
      if (frame_done) done_cnt++;
      if (overrun) ovr_cnt++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_dat = m_axis_tdata;
      prev_last = m_axis_tlast;
    end
  end

  initial begin
    int t0, o0, b0, v;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    nck();
    chk("rst_state", state_o, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);

    // 1: basic capture and full-rate stream
    t0 = done_cnt;
    push_frame(0, 1);
    arm_pulse(0);
    drive_frame(8, 0);
    nck();
    chk("t1_state_stream", state_o, 2);
    chk("t1_busy", busy, 1);
    chk("t1_tvalid_lat1", m_axis_tvalid, 0);
    nck();
    chk("t1_tvalid_lat2", m_axis_tvalid, 0);
    nck();
    chk("t1_tvalid_rise", m_axis_tvalid, 1);
    repeat (7) nck();
    chk("t1_back_to_back", done_cnt - t0, 1);
    nck();
    chk("t1_tvalid_drop", m_axis_tvalid, 0);
    chk("t1_state_idle", state_o, 0);
    wait_frame(t0 + 1);
    chk("t1_busy_idle", busy, 0);

    // 2: stalls from tready pattern 1,0,0
    t0 = done_cnt;
    rdy_toggle = 1'b1;
    push_frame(0, 1);
    arm_pulse(1);
    drive_frame(8, 0);
    wait_frame(t0 + 1);
    rdy_toggle = 1'b0;

    // 3: decimation by 3, then decim=0 keeps every sample
    t0 = done_cnt;
    push_frame(0, 3);
    arm_pulse(3);
    drive_frame(24, 0);
    wait_frame(t0 + 1);
    push_frame(0, 1);
    arm_pulse(0);
    drive_frame(8, 0);
    wait_frame(t0 + 2);

    // 4: continuous mode with input valid held high
    t0 = done_cnt;
    o0 = ovr_cnt;
    push_frame(1, 1);
    push_frame(19, 1);
    continuous = 1'b1;
    decim = DCW'(1);
    @(posedge clk); #1;
    arm = 1'b1;
    s_din_valid = 1'b1;
    s_din = pk(0);
    v = 1;
    for (int c = 0; c < 120 && done_cnt < t0 + 2; c++) begin
      @(posedge clk); #1;
      arm = 1'b0;
      s_din = pk(v);
      if (v == 22) continuous = 1'b0;
      v++;
    end
    s_din_valid = 1'b0;
    chk("t4_frames", done_cnt - t0, 2);
    chk("t4_overrun_count", ovr_cnt - o0, 20);
    wait_frame(t0 + 2);

    // 5: reset while beat 4 is on the bus, then a clean frame
    t0 = done_cnt;
    push_frame(0, 1);
    arm_pulse(0);
    drive_frame(8, 0);
    b0 = beat_cnt;
    wait_beats(b0 + 4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    nck();
    chk("t5_state", state_o, 0);
    chk("t5_tvalid", m_axis_tvalid, 0);
    chk("t5_tdata", m_axis_tdata, 0);
    chk("t5_tlast", m_axis_tlast, 0);
    chk("t5_busy", busy, 0);
    chk("t5_no_frame_done", done_cnt - t0, 0);
    push_frame(40, 1);
    arm_pulse(0);
    drive_frame(8, 40);
    wait_frame(t0 + 1);

    // 6: valid in IDLE and arm held through CAPTURE/STREAM
    t0 = done_cnt;
    o0 = ovr_cnt;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      s_din_valid = 1'b1;
      s_din = pk(7);
    end
    @(posedge clk); #1;
    s_din_valid = 1'b0;
    nck();
    chk("t6_idle_state", state_o, 0);
    chk("t6_idle_overrun", ovr_cnt - o0, 0);
    push_frame(50, 1);
    @(posedge clk); #1;
    arm = 1'b1;
    drive_frame(8, 50);
    nck();
    chk("t6_stream_with_arm", state_o, 2);
    b0 = beat_cnt;
    wait_beats(b0 + 4);
    chk("t6_still_stream", state_o, 2);
    @(posedge clk); #1;
    arm = 1'b0;
    wait_frame(t0 + 1);
    chk("t6_overrun_none", ovr_cnt - o0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
